cam_stream_gen: RTL
===================

# cam_stream_gen

Synthetic OV7670-style pixel-stream transmitter, driving the same vsync/href/px_data interface the camera capture block consumes. It generates complete frames of RGB565 data, two bytes per pixel, from built-in test patterns, with parameterised blanking. It replaces the physical camera in simulation and on-board bring-up, so capture, RGB332 conversion and DPRAM addressing can be checked against known pixel values.

## Interface
- H_ACTIVE, 160, active pixels per line (even, multiple of 8)
- V_ACTIVE, 120, active lines per frame
- H_BLANK, 144, pclk cycles of href-low time per line
- VSYNC_LINES, 3, lines with vsync high
- V_BACK, 17, blank lines after vsync, before first active line
- V_FRONT, 10, blank lines after last active line
- pclk  input  1  pixel-byte clock; all logic on rising edge
- rst  input  1  reset rst, synchronous, active-high; clock pclk
- enable  input  1  level; high = generate frames back-to-back
- pattern_sel  input  2  pattern select, sampled at frame start
- vsync  output  1  frame sync, high during VSYNC lines
- href  output  1  high while px_data carries valid bytes
- px_data  output  8  RGB565 byte stream, 0 when href low
- frame_done  output  1  one-cycle pulse on last cycle of a frame
- busy  output  1  high whenever state is not IDLE

## Operation
- LINE_LEN = 2*H_ACTIVE + H_BLANK; hcnt counts 0..LINE_LEN-1 and wraps, advancing vcnt (line-in-state counter).
- States: IDLE, VSYNC (VSYNC_LINES lines), VBACK (V_BACK), ACTIVE (V_ACTIVE), VFRONT (V_FRONT). Transition when hcnt=LINE_LEN-1 and vcnt = state length-1; vcnt clears on each state change.
- IDLE -> VSYNC when enable=1; hcnt=0, vcnt=0, pattern_sel latched, frame_cnt unchanged.
- VFRONT end -> VSYNC if enable=1 (no idle gap, pattern re-latched, frame_cnt+1), else IDLE. Deasserting enable mid-frame never truncates the frame.
- ACTIVE: href=1 for hcnt < 2*H_ACTIVE; x = hcnt>>1, y = vcnt. Even hcnt sends high byte P[15:8] = {R[4:0],G[5:3]}, odd hcnt sends low byte P[7:0] = {G[2:0],B[4:0]}.
- Patterns P(x,y):
  - 0 colour bars, 8 bars of width H_ACTIVE/8: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1 gray ramp: {x[7:3], x[7:2], x[7:3]}.
  - 2 8x8 checkerboard: FFFF if x[3]^y[3], else 0000.
  - 3 index: (y*H_ACTIVE + x) mod 2^16, computed by an incrementing 16-bit counter cleared at frame start (no multiplier).
- vsync, href, px_data, frame_done are registered outputs; no combinational path from inputs to outputs.

## Timing
- Reset: vsync=0, href=0, px_data=0, frame_done=0, busy=0, state IDLE, all counters 0. rst mid-frame aborts immediately; outputs take reset values the next edge.
- Start latency: enable sampled 1 in IDLE at edge N -> vsync=1, busy=1 after edge N+1.
- vsync high exactly VSYNC_LINES*LINE_LEN cycles; falls when entering VBACK.
- First href rise: (VSYNC_LINES+V_BACK)*LINE_LEN cycles after vsync rise; href high exactly 2*H_ACTIVE cycles per active line, V_ACTIVE pulses per frame.
- px_data changes in the same cycle as href and on every pclk while href=1; consumer samples on rising pclk.
- Frame period = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_LEN; defaults 150*464 = 69600 cycles.
- frame_done high during the cycle where state=VFRONT, vcnt=V_FRONT-1, hcnt=LINE_LEN-1; busy drops the following cycle only if enable=0.
- pattern_sel changes mid-frame have no effect until the next frame start.

## Test plan
- Reset then enable=1, pattern 0: vsync high 1392 cycles, first href 9280 cycles after vsync rise, 120 href pulses of 320 cycles, frame_done after 69600 cycles.
- Pattern 0, line 0: bytes FF FF repeated 20 pixels, then FF E0 for next 20; pixel 159 = 00 00.
- Pattern 3 through capture block: RGB332 written for pixel index 161 matches conversion of 0x00A1; last pixel 0x4AFF.
- Pattern 2: pixel (8,0) = FFFF, (8,8) = 0000, (0,8) = FFFF.
- enable dropped at line 50 of ACTIVE: frame completes, frame_done pulses, busy=0 next cycle, vsync stays 0.
- rst asserted mid ACTIVE: next edge href=0, px_data=0, busy=0; re-enable produces a full-length frame from VSYNC.

Source files
------------

// File: rtl/cam_stream_gen.sv
// Synthetic OV7670-style RGB565 stream source: vsync/href/px_data frames built from test patterns.
// All outputs are registered from the frame state, so they trail the state register by one pclk.
module cam_stream_gen #(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 120,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  px_data,
    output logic        frame_done,
    output logic        busy,
    output logic [2:0]  state_dbg,
    output logic [15:0] frame_cnt
);
    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam logic [15:0] H_LAST   = 16'(LINE_LEN - 1);
    localparam logic [15:0] H_ACT2   = 16'(2 * H_ACTIVE);
    localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t      state, state_nxt;
    logic [15:0] hcnt, hcnt_nxt, vcnt, vcnt_nxt;
    logic [15:0] state_len;
    logic        frame_start, frame_last;
    logic [1:0]  pat;
    logic [15:0] pix_idx;
    logic [15:0] bar_px;
    logic [2:0]  bar_idx;
    logic        act;
    logic [7:0]  x;
    logic [15:0] pix;
    logic [7:0]  byte_val;

    assign state_dbg = state;

    always_comb begin
        state_nxt   = state;
        hcnt_nxt    = hcnt;
        vcnt_nxt    = vcnt;
        frame_start = 1'b0;
        frame_last  = 1'b0;
        case (state)
            VSYNC:   state_len = 16'(VSYNC_LINES);
            VBACK:   state_len = 16'(V_BACK);
            ACTIVE:  state_len = 16'(V_ACTIVE);
            VFRONT:  state_len = 16'(V_FRONT);
            default: state_len = 16'd1;
        endcase
        if (state == IDLE) begin
            if (enable) begin
                state_nxt   = VSYNC;
                frame_start = 1'b1;
            end
        end else begin
            hcnt_nxt = hcnt + 16'd1;
            if (hcnt == H_LAST) begin
                hcnt_nxt = 16'd0;
                vcnt_nxt = vcnt + 16'd1;
                if (vcnt == state_len - 16'd1) begin
                    vcnt_nxt = 16'd0;
                    case (state)
                        VSYNC:  state_nxt = VBACK;
                        VBACK:  state_nxt = ACTIVE;
                        ACTIVE: state_nxt = VFRONT;
                        VFRONT: begin
                            frame_last = 1'b1;
                            if (enable) begin
                                state_nxt   = VSYNC;
                                frame_start = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            hcnt      <= 16'd0;
            vcnt      <= 16'd0;
            pat       <= 2'd0;
            frame_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            vcnt  <= vcnt_nxt;
            if (frame_start) pat <= pattern_sel;
            if (frame_start && frame_last) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign act = (state == ACTIVE) && (hcnt < H_ACT2);
    assign x   = hcnt[8:1];

    // Bar position and pixel index advance after the low byte of each pixel.
    always_ff @(posedge pclk) begin
        if (rst || !act) begin
            bar_px  <= 16'd0;
            bar_idx <= 3'd0;
        end else if (hcnt[0]) begin
            if (bar_px == BAR_LAST) begin
                bar_px  <= 16'd0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 16'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst || frame_start) pix_idx <= 16'd0;
        else if (act && hcnt[0]) pix_idx <= pix_idx + 16'd1;
    end

    always_comb begin
        pix = 16'h0000;
        case (pat)
            2'd0: begin
                case (bar_idx)
                    3'd0:    pix = 16'hFFFF;
                    3'd1:    pix = 16'hFFE0;
                    3'd2:    pix = 16'h07FF;
                    3'd3:    pix = 16'h07E0;
                    3'd4:    pix = 16'hF81F;
                    3'd5:    pix = 16'hF800;
                    3'd6:    pix = 16'h001F;
                    default: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = {x[7:3], x[7:2], x[7:3]};
            2'd2:    pix = (x[3] ^ vcnt[3]) ? 16'hFFFF : 16'h0000;
            default: pix = pix_idx;
        endcase
        byte_val = hcnt[0] ? pix[7:0] : pix[15:8];
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            px_data    <= 8'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            vsync      <= (state == VSYNC);
            href       <= act;
            px_data    <= act ? byte_val : 8'd0;
            frame_done <= frame_last;
            busy       <= (state != IDLE);
        end
    end
endmodule
